// File: rtl/ext_data_mem_responder.sv
// Responder for the core's external data-memory port: word-organised RAM with
// fixed access latency, RV32 byte/half/word loads and stores, one-cycle done pulse.
module ext_data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        mem_write_read,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_in,
  input  logic [2:0]  mem_ctrl,
  output logic [31:0] mem_data_out,
  output logic        mem_done,
  output logic        mem_busy,
  output logic        mem_fault
);

  localparam int         ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam bit         SINGLE    = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [2:0]  ctrl_reg;
  logic        wr_reg;

  logic [31:0] ram [DEPTH_WORDS];

  // With single-cycle latency the access happens on the accept edge, so the
  // live request fields are used; otherwise the latched copy is.
  logic                 live_sel;
  logic [31:0]          acc_addr;
  logic [31:0]          acc_data;
  logic [2:0]           acc_ctrl;
  logic                 acc_wr;
  logic                 do_access;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [31:0]          rd_word;

  always_comb begin
    live_sel  = (state_reg == IDLE);
    acc_addr  = live_sel ? mem_addr       : addr_reg;
    acc_data  = live_sel ? mem_data_in    : data_reg;
    acc_ctrl  = live_sel ? mem_ctrl       : ctrl_reg;
    acc_wr    = live_sel ? mem_write_read : wr_reg;
    do_access = reset &&
                ((SINGLE && (state_reg == IDLE) && mem_enable) ||
                 ((state_reg == BUSY) && (cnt_reg == 4'd1)));
    acc_idx   = acc_addr[ADDR_BITS+1:2];
    rd_word   = ram[acc_idx];
  end

  logic acc_misalign;
  logic acc_illegal;
  logic acc_fault;

  always_comb begin
    acc_misalign = 1'b0;
    acc_illegal  = 1'b0;
    case (acc_ctrl)
      3'b000, 3'b100: acc_misalign = 1'b0;
      3'b001, 3'b101: acc_misalign = acc_addr[0];
      3'b010:         acc_misalign = |acc_addr[1:0];
      default:        acc_illegal  = 1'b1;
    endcase
    // Unsigned variants have no store meaning.
    if (acc_wr && acc_ctrl[2]) acc_illegal = 1'b1;
    acc_fault = acc_misalign | acc_illegal;
  end

  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    st_be   = 4'b1111;
    st_data = acc_data;
    case (acc_ctrl[1:0])
      2'b00: begin
        st_be   = 4'b0001 << acc_addr[1:0];
        st_data = {4{acc_data[7:0]}};
      end
      2'b01: begin
        st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_data[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = acc_data;
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    ld_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_ctrl)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_access && acc_wr && !acc_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) ram[acc_idx][b*8 +: 8] <= st_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      mem_done     <= 1'b0;
      mem_busy     <= 1'b0;
      mem_fault    <= 1'b0;
      mem_data_out <= 32'd0;
      addr_reg     <= 32'd0;
      data_reg     <= 32'd0;
      ctrl_reg     <= 3'd0;
      wr_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          mem_done <= 1'b0;
          if (mem_enable) begin
            addr_reg <= mem_addr;
            data_reg <= mem_data_in;
            ctrl_reg <= mem_ctrl;
            wr_reg   <= mem_write_read;
            cnt_reg  <= CNT_INIT;
            mem_busy <= 1'b1;
            if (SINGLE) begin
              state_reg <= RESP;
              mem_done  <= 1'b1;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= RESP;
            mem_done  <= 1'b1;
          end
        end
        RESP: begin
          mem_done  <= 1'b0;
          mem_busy  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          mem_done  <= 1'b0;
          mem_busy  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase

      if (do_access) begin
        if (acc_fault)    mem_fault    <= 1'b1;
        else if (!acc_wr) mem_data_out <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_ext_data_mem_responder.sv
// Randomised bench: two responders (latency 2 and 3) against a byte-addressed
// memory model; checks latency, single done pulse, load data and fault flag.
module tb_ext_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en2 = 1'b0, en3 = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [2:0]  ctrl = 3'd0;
  logic [31:0] dout2, dout3;
  logic        done2, done3, busy2, busy3, fault2, fault3;

  always #5 clk = ~clk;

  ext_data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .INIT_FILE("")) u_dut2 (
    .clk(clk), .reset(reset), .mem_enable(en2), .mem_write_read(wr), .mem_addr(addr),
    .mem_data_in(wdata), .mem_ctrl(ctrl), .mem_data_out(dout2), .mem_done(done2),
    .mem_busy(busy2), .mem_fault(fault2)
  );

  ext_data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .reset(reset), .mem_enable(en3), .mem_write_read(wr), .mem_addr(addr),
    .mem_data_in(wdata), .mem_ctrl(ctrl), .mem_data_out(dout3), .mem_done(done3),
    .mem_busy(busy3), .mem_fault(fault3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: 4 KiB byte array (1024 words), address taken modulo its size.
  logic [7:0]  model_mem [4096];
  bit          model_fault = 1'b0;
  logic [31:0] model_dout2 = 32'd0, model_dout3 = 32'd0;

  task automatic model_apply(input bit w, input logic [2:0] c, input logic [31:0] a,
                             input logic [31:0] d, output bit flt, output logic [31:0] ld);
    int size;
    int base;
    logic [31:0] val;
    case (c)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    ld  = 32'd0;
    flt = (size == 0) || (w && c >= 3'd4);
    if (!flt && (a % size) != 0) flt = 1'b1;
    if (!flt) begin
      base = int'(a % 4096);
      if (w) begin
        for (int i = 0; i < size; i++) model_mem[base + i] = d[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < size; i++) val = val | (32'(model_mem[base + i]) << (8*i));
        if (c < 3'd4 && size < 4 && val[8*size-1])
          val = val | ~((32'd1 << (8*size)) - 32'd1);
        ld = val;
      end
    end
  endtask

  task automatic do_op(input bit w, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
    bit flt;
    logic [31:0] ld;
    int first2, first3, n2, n3;
    model_apply(w, c, a, d, flt, ld);
    if (flt) model_fault = 1'b1;
    else if (!w) begin
      model_dout2 = ld;
      model_dout3 = ld;
    end
    @(negedge clk);
    wr = w; ctrl = c; addr = a; wdata = d; en2 = 1'b1; en3 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0; en3 = 1'b0;
    first2 = -1; first3 = -1; n2 = 0; n3 = 0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == 0) begin
        check({tag, " busy2"}, 32'(busy2), 32'd1);
        check({tag, " busy3"}, 32'(busy3), 32'd1);
      end
      if (done2) begin if (first2 < 0) first2 = k; n2++; end
      if (done3) begin if (first3 < 0) first3 = k; n3++; end
    end
    check({tag, " lat2"}, 32'(first2), 32'd1);
    check({tag, " pulses2"}, 32'(n2), 32'd1);
    check({tag, " lat3"}, 32'(first3), 32'd2);
    check({tag, " pulses3"}, 32'(n3), 32'd1);
    check({tag, " dout2"}, dout2, model_dout2);
    check({tag, " dout3"}, dout3, model_dout3);
    check({tag, " fault2"}, 32'(fault2), 32'(model_fault));
    check({tag, " fault3"}, 32'(fault3), 32'(model_fault));
    $display("op %s wr=%0d ctrl=%0d addr=%h data=%h -> dout=%h fault=%0d",
             tag, w, c, a, d, dout2, fault2);
  endtask

  function automatic logic [31:0] model_word(input int a);
    return {model_mem[a+3], model_mem[a+2], model_mem[a+1], model_mem[a]};
  endfunction

  initial begin
    logic [31:0] a, d, saved;
    logic [2:0]  c;
    bit          w, flt;
    int          n2, n3, first3;
    logic [31:0] ld;

    repeat (3) @(posedge clk);
    #1;
    check("rst done2", 32'(done2), 32'd0);
    check("rst busy2", 32'(busy2), 32'd0);
    check("rst fault2", 32'(fault2), 32'd0);
    check("rst dout2", dout2, 32'd0);
    check("rst done3", 32'(done3), 32'd0);
    check("rst dout3", dout3, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) do_op(1'b1, 3'd2, 32'(i*4), $urandom, "prefill");

    do_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
    do_op(1'b0, 3'd2, 32'h10, 32'd0, "lw10");
    check("lw10 const", dout2, 32'hDEADBEEF);
    do_op(1'b1, 3'd0, 32'h13, 32'h80, "sb13");
    do_op(1'b0, 3'd0, 32'h13, 32'd0, "lb13");
    check("lb13 const", dout2, 32'hFFFFFF80);
    do_op(1'b0, 3'd4, 32'h13, 32'd0, "lbu13");
    check("lbu13 const", dout2, 32'h00000080);
    do_op(1'b0, 3'd2, 32'h10, 32'd0, "lw10b");
    check("lw10b const", dout2, 32'h80ADBEEF);
    do_op(1'b1, 3'd1, 32'h22, 32'h8001, "sh22");
    do_op(1'b0, 3'd1, 32'h22, 32'd0, "lh22");
    check("lh22 const", dout2, 32'hFFFF8001);
    do_op(1'b0, 3'd5, 32'h22, 32'd0, "lhu22");
    check("lhu22 const", dout2, 32'h00008001);
    do_op(1'b0, 3'd1, 32'h21, 32'd0, "lh21");
    check("lh21 fault", 32'(fault2), 32'd1);
    check("lh21 dout kept", dout2, 32'h00008001);

    // Enable held through the whole latency-3 transaction: one access only.
    model_apply(1'b0, 3'd2, 32'h10, 32'd0, flt, ld);
    model_dout3 = ld;
    @(negedge clk);
    wr = 1'b0; ctrl = 3'd2; addr = 32'h10; en3 = 1'b1;
    n2 = 0; n3 = 0; first3 = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 3) en3 = 1'b0;
      if (done2) n2++;
      if (done3) begin if (first3 < 0) first3 = k; n3++; end
    end
    check("hold lat3", 32'(first3), 32'd2);
    check("hold pulses3", 32'(n3), 32'd1);
    check("hold idle2", 32'(n2), 32'd0);
    check("hold dout3", dout3, model_dout3);
    $display("op hold lw10 on latency-3 -> dout=%h pulses=%0d", dout3, n3);

    do_op(1'b1, 3'd2, 32'h00001000, 32'h12345678, "sw1000");
    do_op(1'b0, 3'd2, 32'h00000000, 32'd0, "lw0wrap");
    check("wrap const", dout2, 32'h12345678);

    // Reset during the BUSY cycle of a store abandons it.
    saved = model_word(32'h30);
    @(negedge clk);
    wr = 1'b1; ctrl = 3'd2; addr = 32'h30; wdata = ~saved; en2 = 1'b1; en3 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0; en3 = 1'b0; reset = 1'b0;
    n2 = 0; n3 = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst busy2", 32'(busy2), 32'd0);
    check("midrst busy3", 32'(busy3), 32'd0);
    check("midrst fault2", 32'(fault2), 32'd0);
    check("midrst dout2", dout2, 32'd0);
    check("midrst dout3", dout3, 32'd0);
    for (int k = 0; k < 6; k++) begin
      if (done2) n2++;
      if (done3) n3++;
      @(posedge clk); #1;
    end
    check("midrst pulses2", 32'(n2), 32'd0);
    check("midrst pulses3", 32'(n3), 32'd0);
    model_fault = 1'b0; model_dout2 = 32'd0; model_dout3 = 32'd0;
    $display("op reset mid-busy sw30 -> busy=%0d done pulses=%0d", busy2, n2);
    do_op(1'b0, 3'd2, 32'h30, 32'd0, "lw30");
    check("lw30 unchanged", dout2, saved);

    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      if (i < 60) begin
        if (w) c = 3'($urandom_range(0, 2));
        else begin
          c = 3'($urandom_range(0, 4));
          if (c == 3'd3) c = 3'd5;
        end
        a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
        if (c[1:0] == 2'd1) a[0] = 1'b0;
        if (c == 3'd2) a[1:0] = 2'd0;
      end else begin
        c = 3'($urandom_range(0, 7));
        a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      end
      d = $urandom;
      do_op(w, c, a, d, i < 60 ? "rand" : "rand_any");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
